// File: rtl/spi_slave_mem_bridge.sv
// rtl/spi_slave_mem_bridge.sv - SPI mode-0 slave that decodes two-byte frames into en/valid memory accesses
// SPI pins are oversampled by clk; one memory access per selected frame.
module spi_slave_mem_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       mem_en,
  output logic       mem_wr_en,
  output logic [5:0] mem_addr,
  output logic [7:0] mem_wr_data,
  input  logic [7:0] mem_rd_data,
  input  logic       mem_valid,
  output logic       busy,
  output logic       frame_done,
  output logic       err_overrun,
  output logic       err_timeout
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, CMD, RD_REQ, WR_DATA, WR_REQ, REL, FIN} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_s, cs_s, mosi_s, sclk_q, cs_q;
  logic sclk_rise, sclk_fall, cs_fall;

  state_t        state;
  logic          armed, ovr, aborted, timed_out;
  logic [6:0]    rx_sh;
  logic [2:0]    rcnt;
  logic [4:0]    fcnt;
  logic [7:0]    tx;
  logic [TW-1:0] tcnt;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = cs_q & ~cs_s;

  assign spi_miso_oe = busy & ~cs_s;

  // cs_n chain resets to 0 so a frame already running at reset release never looks like a fresh cs_n fall
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      armed       <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
      mem_en      <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      spi_miso    <= 1'b0;
      ovr         <= 1'b0;
      aborted     <= 1'b0;
      timed_out   <= 1'b0;
      rx_sh       <= '0;
      rcnt        <= '0;
      fcnt        <= '0;
      tx          <= '0;
      tcnt        <= '0;
    end else begin
      frame_done <= 1'b0;
      if (cs_s) armed <= 1'b0 | 1'b1;

      // Falls 1-8 belong to byte 0 (MISO stays 0); the 8th presents tx[7], falls 9-16 shift byte 1
      if (sclk_fall && state != IDLE && fcnt != 5'd16) begin
        fcnt <= fcnt + 5'd1;
        if (fcnt == 5'd7) begin
          spi_miso <= tx[7];
        end else if (fcnt >= 5'd8) begin
          tx       <= {tx[6:0], 1'b0};
          spi_miso <= tx[6];
        end
      end

      case (state)
        IDLE: begin
          if (armed && cs_fall) begin
            state     <= CMD;
            busy      <= 1'b1;
            rcnt      <= '0;
            fcnt      <= '0;
            tx        <= '0;
            spi_miso  <= 1'b0;
            ovr       <= 1'b0;
            aborted   <= 1'b0;
            timed_out <= 1'b0;
          end
        end

        CMD: begin
          if (cs_s) begin
            state    <= IDLE;
            busy     <= 1'b0;
            spi_miso <= 1'b0;
          end else if (sclk_rise) begin
            rx_sh <= {rx_sh[5:0], mosi_s};
            rcnt  <= rcnt + 3'd1;
            if (rcnt == 3'd7) begin
              mem_addr <= {rx_sh[4:0], mosi_s};
              if (rx_sh[6]) begin
                state <= WR_DATA;
              end else begin
                // Read data defaults to 0xFF until the memory answers in time
                state     <= RD_REQ;
                mem_en    <= ~mem_valid;
                mem_wr_en <= 1'b0;
                tcnt      <= '0;
                tx        <= 8'hFF;
              end
            end
          end
        end

        WR_DATA: begin
          if (cs_s) begin
            state    <= IDLE;
            busy     <= 1'b0;
            spi_miso <= 1'b0;
          end else if (sclk_rise) begin
            rx_sh <= {rx_sh[5:0], mosi_s};
            rcnt  <= rcnt + 3'd1;
            if (rcnt == 3'd7) begin
              state       <= WR_REQ;
              mem_wr_data <= {rx_sh, mosi_s};
              mem_en      <= ~mem_valid;
              mem_wr_en   <= 1'b1;
              tcnt        <= '0;
            end
          end
        end

        RD_REQ, WR_REQ: begin
          if (cs_s) aborted <= 1'b1;
          if (state == RD_REQ && sclk_rise) begin
            err_overrun <= 1'b1;
            ovr         <= 1'b1;
          end
          // A request only goes out once a previous completion flag has dropped
          if (!mem_en) begin
            if (!mem_valid) begin
              mem_en <= 1'b1;
              tcnt   <= '0;
            end
          end else if (mem_valid) begin
            mem_en <= 1'b0;
            state  <= REL;
            if (state == RD_REQ && !ovr && !sclk_rise) begin
              tx       <= mem_rd_data;
              spi_miso <= mem_rd_data[7];
            end
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            mem_en      <= 1'b0;
            err_timeout <= 1'b1;
            timed_out   <= 1'b1;
            state       <= REL;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        REL: begin
          if (!mem_valid) begin
            if (aborted) begin
              state    <= IDLE;
              busy     <= 1'b0;
              spi_miso <= 1'b0;
            end else begin
              state <= FIN;
            end
          end
        end

        FIN: begin
          if (cs_s) begin
            state      <= IDLE;
            busy       <= 1'b0;
            spi_miso   <= 1'b0;
            frame_done <= ~timed_out;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_mem_bridge.sv
// tb/tb_spi_slave_mem_bridge.sv - randomized SPI master and memory emulator around spi_slave_mem_bridge
module tb_spi_slave_mem_bridge;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       mem_valid = 1'b0;
  logic [7:0] mem_rd_data = 8'h00;
  logic       spi_miso, spi_miso_oe, mem_en, mem_wr_en, busy, frame_done, err_overrun, err_timeout;
  logic [5:0] mem_addr;
  logic [7:0] mem_wr_data;
  logic [21:0] outs;

  spi_slave_mem_bridge #(.SYNC_STAGES(2), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .mem_en(mem_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_valid(mem_valid),
    .busy(busy), .frame_done(frame_done), .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  assign outs = {spi_miso, spi_miso_oe, mem_en, mem_wr_en, mem_addr, mem_wr_data,
                 busy, frame_done, err_overrun, err_timeout};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] emu [64];
  logic [7:0] ref_mem [64];
  bit   respond = 1'b1;
  bit   stale = 1'b0;
  int   latency = 1;
  int   lat_cnt = 0;
  int   fd_cnt = 0, en_rise_cnt = 0, acc_cnt = 0, viol = 0, run = 0, last_run = 0;
  logic prev_en = 1'b0;
  logic [5:0] last_addr = '0;
  logic last_we = 1'b0;
  logic [7:0] last_wd = '0;

  // Memory emulator plus protocol monitor, sampled 1 time unit after each clock edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (frame_done) fd_cnt++;
      if (mem_en && !prev_en) en_rise_cnt++;
      if (mem_en) run++;
      else if (prev_en) begin
        last_run = run;
        run = 0;
      end
      if (mem_en && mem_valid) viol++;
      prev_en = mem_en;
      if (stale) mem_valid = 1'b1;
      else if (mem_valid && !mem_en) mem_valid = 1'b0;
      else if (mem_en && !mem_valid && respond) begin
        if (lat_cnt >= latency) begin
          if (mem_wr_en) emu[mem_addr] = mem_wr_data;
          else mem_rd_data = emu[mem_addr];
          last_addr = mem_addr;
          last_we   = mem_wr_en;
          last_wd   = mem_wr_data;
          acc_cnt++;
          mem_valid = 1'b1;
          lat_cnt   = 0;
        end else lat_cnt++;
      end else if (!mem_en) lat_cnt = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic spi_bit(input logic b, output logic r);
    spi_mosi = b;
    clks(HALF);
    r = spi_miso;
    spi_sclk = 1'b1;
    clks(HALF);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] t, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      logic b;
      spi_bit(t[i], b);
      r[i] = b;
    end
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input int gap, input int tail,
                       output logic [7:0] r0, output logic [7:0] r1);
    spi_cs_n = 1'b0;
    clks(HALF);
    spi_byte(b0, r0);
    clks(gap);
    spi_byte(b1, r1);
    clks(tail);
    spi_cs_n = 1'b1;
    clks(12);
  endtask

  task automatic test_reset();
    clks(4);
    checks++; if (outs !== 22'h0) begin errors++; $display("FAIL reset_outputs got %0h exp 0", outs); end
    rst = 1'b0;
    clks(10);
    checks++; if (outs !== 22'h0) begin errors++; $display("FAIL idle_outputs got %0h exp 0", outs); end
  endtask

  task automatic test_write();
    logic [7:0] r0, r1;
    int fd0, acc0;
    fd0 = fd_cnt; acc0 = acc_cnt; latency = 1;
    spi_cs_n = 1'b0;
    clks(HALF);
    checks++; if ({busy, spi_miso_oe} !== 2'b11) begin errors++; $display("FAIL write_busy_oe got %b exp 11", {busy, spi_miso_oe}); end
    spi_byte(8'h85, r0);
    spi_byte(8'h3C, r1);
    clks(12);
    checks++; if ({last_we, last_addr, last_wd} !== {1'b1, 6'h05, 8'h3C}) begin errors++; $display("FAIL write_access got %0h exp %0h", {last_we, last_addr, last_wd}, {1'b1, 6'h05, 8'h3C}); end
    spi_cs_n = 1'b1;
    clks(12);
    ref_mem[5] = 8'h3C;
    checks++; if (emu[5] !== 8'h3C) begin errors++; $display("FAIL write_mem got %0h exp 3c", emu[5]); end
    checks++; if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL write_frame_done got %0d exp %0d", fd_cnt, fd0 + 1); end
    checks++; if (acc_cnt !== acc0 + 1) begin errors++; $display("FAIL write_one_access got %0d exp %0d", acc_cnt, acc0 + 1); end
    checks++; if (r0 !== 8'h00) begin errors++; $display("FAIL write_miso_byte0 got %0h exp 0", r0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_read_gap();
    logic [7:0] r0, r1;
    int fd0;
    fd0 = fd_cnt; latency = 2;
    frame(8'h05, 8'h00, 16, 12, r0, r1);
    checks++; if (r1 !== ref_mem[5]) begin errors++; $display("FAIL read_miso got %0h exp %0h", r1, ref_mem[5]); end
    checks++; if (r0 !== 8'h00) begin errors++; $display("FAIL read_miso_byte0 got %0h exp 0", r0); end
    checks++; if ({last_we, last_addr} !== {1'b0, 6'h05}) begin errors++; $display("FAIL read_access got %0h exp 05", {last_we, last_addr}); end
    checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL read_no_overrun got %b exp 0", err_overrun); end
    checks++; if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL read_frame_done got %0d exp %0d", fd_cnt, fd0 + 1); end
  endtask

  task automatic test_random();
    logic [7:0] r0, r1, d;
    logic [5:0] a;
    logic wr, b6;
    int fd0;
    for (int n = 0; n < 10; n++) begin
      a  = 6'($urandom_range(0, 63));
      d  = 8'($urandom);
      wr = 1'($urandom_range(0, 1));
      b6 = 1'($urandom_range(0, 1));
      latency = $urandom_range(0, 4);
      fd0 = fd_cnt;
      frame({wr, b6, a}, d, $urandom_range(16, 24), 12, r0, r1);
      checks++; if ({last_we, last_addr} !== {wr, a}) begin errors++; $display("FAIL rand_access n=%0d got %0h exp %0h", n, {last_we, last_addr}, {wr, a}); end
      if (wr) ref_mem[a] = d;
      else begin
        checks++; if (r1 !== ref_mem[a]) begin errors++; $display("FAIL rand_read n=%0d got %0h exp %0h", n, r1, ref_mem[a]); end
      end
      checks++; if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL rand_frame_done n=%0d got %0d exp %0d", n, fd_cnt, fd0 + 1); end
    end
    for (int i = 0; i < 64; i++) begin
      checks++; if (emu[i] !== ref_mem[i]) begin errors++; $display("FAIL rand_mem[%0d] got %0h exp %0h", i, emu[i], ref_mem[i]); end
    end
    checks++; if ({err_overrun, err_timeout, viol} !== {2'b00, 32'd0}) begin errors++; $display("FAIL rand_flags got ovr=%b to=%b viol=%0d exp 0", err_overrun, err_timeout, viol); end
  endtask

  task automatic test_overrun();
    logic [7:0] r0, r1;
    int fd0, acc0, en0;
    fd0 = fd_cnt; acc0 = acc_cnt; en0 = en_rise_cnt; latency = 30;
    frame(8'h40 | 8'h21, 8'h00, 0, 12, r0, r1);
    checks++; if (r1 !== 8'hFF) begin errors++; $display("FAIL overrun_miso got %0h exp ff", r1); end
    checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b exp 1", err_overrun); end
    checks++; if ({acc_cnt - acc0, en_rise_cnt - en0} !== {32'd1, 32'd1}) begin errors++; $display("FAIL overrun_handshake got acc=%0d en=%0d exp 1 1", acc_cnt - acc0, en_rise_cnt - en0); end
    checks++; if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL overrun_frame_done got %0d exp %0d", fd_cnt, fd0 + 1); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL overrun_protocol got %0d exp 0", viol); end
    latency = 1;
  endtask

  task automatic test_abort();
    logic [7:0] r0, r1;
    logic b;
    int fd0, en0;
    fd0 = fd_cnt; en0 = en_rise_cnt;
    spi_cs_n = 1'b0;
    clks(HALF);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
    spi_cs_n = 1'b1;
    clks(12);
    checks++; if (en_rise_cnt !== en0) begin errors++; $display("FAIL abort_no_mem_en got %0d exp %0d", en_rise_cnt, en0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if (fd_cnt !== fd0) begin errors++; $display("FAIL abort_no_frame_done got %0d exp %0d", fd_cnt, fd0); end
    frame(8'h80 | 8'h2A, 8'hA7, 0, 12, r0, r1);
    ref_mem[42] = 8'hA7;
    checks++; if (emu[42] !== 8'hA7) begin errors++; $display("FAIL abort_next_write got %0h exp a7", emu[42]); end
    checks++; if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL abort_next_done got %0d exp %0d", fd_cnt, fd0 + 1); end
  endtask

  task automatic test_timeout();
    logic [7:0] r0, r1;
    int fd0;
    fd0 = fd_cnt; respond = 1'b0;
    frame(8'h80 | 8'h07, 8'h11, 0, 90, r0, r1);
    respond = 1'b1;
    checks++; if (last_run !== 64) begin errors++; $display("FAIL timeout_len got %0d exp 64", last_run); end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag got %b exp 1", err_timeout); end
    checks++; if (fd_cnt !== fd0) begin errors++; $display("FAIL timeout_no_done got %0d exp %0d", fd_cnt, fd0); end
    checks++; if (emu[7] !== ref_mem[7]) begin errors++; $display("FAIL timeout_mem got %0h exp %0h", emu[7], ref_mem[7]); end
  endtask

  task automatic test_late_valid();
    logic [7:0] r0, r1;
    int fd0;
    fd0 = fd_cnt; latency = 0;
    stale = 1'b1;
    spi_cs_n = 1'b0;
    clks(HALF);
    spi_byte(8'h80 | 8'h09, r0);
    spi_byte(8'h5A, r1);
    clks(20);
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL late_valid_blocks got %b exp 0", mem_en); end
    stale = 1'b0;
    clks(20);
    ref_mem[9] = 8'h5A;
    checks++; if (emu[9] !== 8'h5A) begin errors++; $display("FAIL late_valid_write got %0h exp 5a", emu[9]); end
    spi_cs_n = 1'b1;
    clks(12);
    checks++; if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL late_valid_done got %0d exp %0d", fd_cnt, fd0 + 1); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL late_valid_protocol got %0d exp 0", viol); end
  endtask

  task automatic test_rst_mid();
    logic [7:0] r0, r1;
    int fd0, en0;
    respond = 1'b0;
    spi_cs_n = 1'b0;
    clks(HALF);
    spi_byte(8'h80 | 8'h0C, r0);
    spi_byte(8'h55, r1);
    clks(10);
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rst_mid_pending got %b exp 1", mem_en); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mid_drop got %b exp 0", mem_en); end
    clks(3);
    rst = 1'b0;
    respond = 1'b1;
    en0 = en_rise_cnt;
    spi_byte(8'h80 | 8'h0D, r0);
    spi_byte(8'h66, r1);
    clks(12);
    checks++; if (en_rise_cnt !== en0) begin errors++; $display("FAIL rst_mid_ignored got %0d exp %0d", en_rise_cnt, en0); end
    checks++; if ({busy, err_timeout, err_overrun} !== 3'b000) begin errors++; $display("FAIL rst_mid_state got %b exp 000", {busy, err_timeout, err_overrun}); end
    spi_cs_n = 1'b1;
    clks(12);
    fd0 = fd_cnt;
    frame(8'h80 | 8'h0D, 8'h77, 0, 12, r0, r1);
    ref_mem[13] = 8'h77;
    checks++; if (emu[13] !== 8'h77) begin errors++; $display("FAIL rst_next_write got %0h exp 77", emu[13]); end
    checks++; if (emu[12] !== ref_mem[12]) begin errors++; $display("FAIL rst_no_write got %0h exp %0h", emu[12], ref_mem[12]); end
    checks++; if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL rst_next_done got %0d exp %0d", fd_cnt, fd0 + 1); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      emu[i]     = 8'($urandom);
      ref_mem[i] = emu[i];
    end
    test_reset();
    test_write();
    test_read_gap();
    test_random();
    test_overrun();
    test_abort();
    test_timeout();
    test_late_valid();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
